cpu_gpio_bank: RTL and testbench
================================

CPU_GPIO_BANK -- requirements
Module: cpu_gpio_bank

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 3, number of GPIO ports (1..4).
REQ-002 SHALL have parameter WIDTH, default 8, bits per port (1..8).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port port_sel  input  2  index of the port targeted by load/read.
REQ-006 SHALL have port load_tris  input  1  write alu_output into the selected port's TRIS register.
REQ-007 SHALL have port load_gpio  input  1  write alu_output into the selected port's output latch.
REQ-008 SHALL have port alu_output  input  WIDTH  write data.
REQ-009 SHALL have port ioc_clear  input  NUM_PORTS  per-port clear of interrupt-on-change flag.
REQ-010 SHALL have port gpio_bus  inout  NUM_PORTS*WIDTH  pins; port p occupies bits [p*WIDTH +: WIDTH].
REQ-011 SHALL have port gpio_input  output  NUM_PORTS*WIDTH  synchronised pin values, same packing.
REQ-012 SHALL have port rd_data  output  WIDTH  synchronised pin value of the port_sel port.
REQ-013 SHALL have port ioc_flag  output  NUM_PORTS  sticky change flags.
REQ-014 SHALL have port irq  output  1  OR of all ioc_flag bits.

Function
REQ-015 SHALL drive each pin bit with its latch bit when its TRIS bit is 0, high-Z when 1.
REQ-016 SHALL pass each pin through a two-flop synchronizer; gpio_input reflects a pin change on the 2nd rising edge after it.
REQ-017 SHALL report the pin value on gpio_input regardless of direction, so output bits read back their driven value.
REQ-018 SHALL make rd_data combinational from gpio_input using port_sel; rd_data SHALL be 0 when port_sel >= NUM_PORTS.
REQ-019 SHALL update TRIS/latch of port port_sel on the edge where load_tris/load_gpio is high; both high in one cycle updates both.
REQ-020 SHALL ignore loads when port_sel >= NUM_PORTS; no register changes.
REQ-021 SHALL take effect on pins in the cycle after the load edge (registered output enable and data).
REQ-022 SHALL hold a third-stage copy of gpio_input; a bit differing from its copy while its TRIS bit is 1 is a change event for that port.
REQ-023 SHALL set ioc_flag[p] on the edge after a change event; flag stays set until ioc_clear[p].
REQ-024 SHALL let set win over clear when a change event and ioc_clear[p] coincide.
REQ-025 SHALL not generate a change event from a bit whose TRIS switches from 0 to 1 in the same cycle; the third-stage copy SHALL reload on every edge.
REQ-026 SHALL drive irq as combinational OR of ioc_flag.

Reset
REQ-027 SHALL, on rst low, immediately set all TRIS bits to 1 (all pins high-Z), latches to 0, synchronizer and copy stages to 0, ioc_flag to 0.
REQ-028 SHALL hold all outputs at reset values while rst is low, gpio_input 0, rd_data 0, irq 0.
REQ-029 SHALL suppress change events on the first two edges after rst deasserts so synchronizer fill does not set flags.

Configuration
REQ-030 SHALL compile interrupt-on-change logic only when GPIO_IOC_EN is defined.
REQ-031 SHALL, without GPIO_IOC_EN, tie ioc_flag and irq to 0, ignore ioc_clear, and omit third-stage copy flops.

Verification
REQ-032 Reset then port_sel=1, load_tris with 8'h00, load_gpio with 8'hA5 -> gpio_bus[15:8]=8'hA5 next cycle; gpio_input[15:8]=8'hA5 two edges later; other ports high-Z.
REQ-033 All TRIS=1, drive gpio_bus[7:0]=8'h3C externally -> gpio_input[7:0]=8'h3C on 2nd edge; rd_data=8'h3C with port_sel=0.
REQ-034 port_sel=3 with NUM_PORTS=3, load_gpio 8'hFF -> no register change, rd_data=8'h00.
REQ-035 GPIO_IOC_EN: toggle input pin of port 2 -> ioc_flag=3'b100, irq=1; pulse ioc_clear[2] with new toggle in same cycle -> flag stays 1; clear alone -> 0.
REQ-036 Assert rst low mid-write with port 0 driving 8'h55 -> pins high-Z asynchronously; no ioc_flag set in first two edges after release.
REQ-037 Without GPIO_IOC_EN, toggle inputs and pulse ioc_clear -> ioc_flag=0, irq=0 throughout.

Source files
------------

// File: rtl/cpu_gpio_bank.sv
// GPIO bank: per-port TRIS/latch registers, 2-flop input sync, optional IOC.
// Ports: clk, rst (async active-low), port_sel, load_tris, load_gpio,
//   alu_output, ioc_clear, gpio_bus (inout), gpio_input, rd_data, ioc_flag, irq.
// Define GPIO_IOC_EN to build the interrupt-on-change logic.
module cpu_gpio_bank #(
    parameter int NUM_PORTS = 3,
    parameter int WIDTH     = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [1:0]                 port_sel,
    input  logic                       load_tris,
    input  logic                       load_gpio,
    input  logic [WIDTH-1:0]           alu_output,
    input  logic [NUM_PORTS-1:0]       ioc_clear,
    inout  wire  [NUM_PORTS*WIDTH-1:0] gpio_bus,
    output logic [NUM_PORTS*WIDTH-1:0] gpio_input,
    output logic [WIDTH-1:0]           rd_data,
    output logic [NUM_PORTS-1:0]       ioc_flag,
    output logic                       irq
);

    localparam int NW = NUM_PORTS * WIDTH;

    logic [NW-1:0] r_tris;
    logic [NW-1:0] r_latch;
    logic [NW-1:0] r_sync1;
    logic [NW-1:0] r_sync2;
    logic [WIDTH-1:0] w_rd;

    // TRIS bit 1 releases the pin
    for (genvar b = 0; b < NW; b++) begin : g_pin
        assign gpio_bus[b] = r_tris[b] ? 1'bz : r_latch[b];
    end

    // Out-of-range port_sel matches no port, so loads are dropped
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tris  <= '1;
            r_latch <= '0;
        end else begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (int'(port_sel) == p) begin
                    if (load_tris)
                        r_tris[p*WIDTH +: WIDTH] <= alu_output;
                    if (load_gpio)
                        r_latch[p*WIDTH +: WIDTH] <= alu_output;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= gpio_bus;
            r_sync2 <= r_sync1;
        end
    end

    assign gpio_input = r_sync2;

    always_comb begin
        w_rd = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (int'(port_sel) == p)
                w_rd = r_sync2[p*WIDTH +: WIDTH];
        end
    end

    assign rd_data = w_rd;

`ifdef GPIO_IOC_EN
    logic [NW-1:0]        r_copy;
    logic [1:0]           r_arm;
    logic [NUM_PORTS-1:0] r_flag;
    logic [NUM_PORTS-1:0] w_event;
    logic                 w_armed;

    // Events are masked until the synchronizer has filled after reset
    assign w_armed = (r_arm == 2'd2);

    // Uses the pre-edge TRIS, so a bit just switching to input
    // cannot raise an event in that cycle
    always_comb begin
        w_event = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            w_event[p] = w_armed &&
                (|((r_sync2[p*WIDTH +: WIDTH] ^ r_copy[p*WIDTH +: WIDTH])
                   & r_tris[p*WIDTH +: WIDTH]));
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_copy <= '0;
            r_arm  <= 2'd0;
            r_flag <= '0;
        end else begin
            r_copy <= r_sync2;
            if (!w_armed)
                r_arm <= r_arm + 2'd1;
            // set has priority over clear
            r_flag <= w_event | (r_flag & ~ioc_clear);
        end
    end

    assign ioc_flag = r_flag;
    assign irq      = |r_flag;
`else
    logic w_unused_clr;

    assign w_unused_clr = ^ioc_clear;
    assign ioc_flag     = '0;
    assign irq          = 1'b0;
`endif

endmodule

// File: tb/tb_cpu_gpio_bank.sv
// Testbench for cpu_gpio_bank: directed cases plus randomized traffic
// compared every cycle against a behavioural model.
module tb_cpu_gpio_bank;

    localparam int NP = 3;
    localparam int W  = 8;
    localparam int NW = NP * W;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [1:0]    port_sel = 2'd0;
    logic          load_tris = 1'b0;
    logic          load_gpio = 1'b0;
    logic [W-1:0]  alu_output = '0;
    logic [NP-1:0] ioc_clear = '0;
    wire  [NW-1:0] gpio_bus;
    logic [NW-1:0] gpio_input;
    logic [W-1:0]  rd_data;
    logic [NP-1:0] ioc_flag;
    logic          irq;

    logic [NW-1:0] ext_en  = '1;
    logic [NW-1:0] ext_val = '0;

    for (genvar b = 0; b < NW; b++) begin : g_ext
        assign gpio_bus[b] = ext_en[b] ? ext_val[b] : 1'bz;
    end

    cpu_gpio_bank #(.NUM_PORTS(NP), .WIDTH(W)) dut (
        .clk(clk), .rst(rst), .port_sel(port_sel),
        .load_tris(load_tris), .load_gpio(load_gpio),
        .alu_output(alu_output), .ioc_clear(ioc_clear),
        .gpio_bus(gpio_bus), .gpio_input(gpio_input),
        .rd_data(rd_data), .ioc_flag(ioc_flag), .irq(irq)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // model state
    logic [NW-1:0] m_tris, m_latch, m_gi, m_copy;
    logic [NW-1:0] m_q[$];
    logic [NP-1:0] m_flag;
    int            m_edges;

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_tris  = '1;
        m_latch = '0;
        m_gi    = '0;
        m_copy  = '0;
        m_flag  = '0;
        m_edges = 0;
        m_q     = {};
        m_q.push_back('0);
        m_q.push_back('0);
    endtask

    function automatic logic [NW-1:0] model_pins();
        return (m_tris & ext_val) | (~m_tris & m_latch);
    endfunction

    // one rising edge, using the inputs present just before it
    task automatic model_step();
        logic [NW-1:0] pin;
        logic [NP-1:0] ev;
        int sel;
        pin = model_pins();
        sel = int'(port_sel);
        ev = '0;
        for (int p = 0; p < NP; p++)
            if ((((m_gi ^ m_copy) & m_tris) >> (p*W)) & {{(NW-W){1'b0}}, {W{1'b1}}})
                ev[p] = (m_edges >= 2);
`ifdef GPIO_IOC_EN
        m_flag = ev | (m_flag & ~ioc_clear);
`else
        m_flag = '0;
`endif
        m_copy = m_gi;
        m_q.push_back(pin);
        void'(m_q.pop_front());
        m_gi = m_q[0];
        if (sel < NP) begin
            if (load_tris) m_tris[sel*W +: W] = alu_output;
            if (load_gpio) m_latch[sel*W +: W] = alu_output;
        end
        m_edges++;
    endtask

    task automatic compare_all();
        logic [W-1:0] exp_rd;
        int sel;
        sel = int'(port_sel);
        exp_rd = (sel < NP) ? m_gi[sel*W +: W] : '0;
        chk("pins", 32'(gpio_bus), 32'(model_pins()));
        chk("gpio_input", 32'(gpio_input), 32'(m_gi));
        chk("rd_data", 32'(rd_data), 32'(exp_rd));
        chk("ioc_flag", 32'(ioc_flag), 32'(m_flag));
        chk("irq", 32'(irq), 32'(|m_flag));
    endtask

    task automatic step();
        @(posedge clk);
        if (rst) model_step();
        #1;
        ext_en = m_tris;
        @(negedge clk);
        compare_all();
    endtask

    logic [NP-1:0] exp_f;

    initial begin
        #1 rst = 1'b0;
        model_reset();
        #1;
        chk("rst_gpio_input", 32'(gpio_input), 32'h0);
        chk("rst_rd_data", 32'(rd_data), 32'h0);
        chk("rst_ioc_flag", 32'(ioc_flag), 32'h0);
        chk("rst_irq", 32'(irq), 32'h0);
        ext_val = 24'h5A_C3_11;
        step();
        step();
        ext_val = '0;
        #2 rst = 1'b1;
        step();
        step();
        chk("fill_no_flag", 32'(ioc_flag), 32'h0);

        // port 1 as output driving A5
        port_sel = 2'd1; load_tris = 1'b1; alu_output = 8'h00;
        step();
        load_tris = 1'b0; load_gpio = 1'b1; alu_output = 8'hA5;
        step();
        load_gpio = 1'b0;
        chk("p1_pins_A5", 32'(gpio_bus[15:8]), 32'hA5);
        chk("p0_hiz", 32'(gpio_bus[7:0]), 32'(ext_val[7:0]));
        step();
        step();
        chk("p1_input_A5", 32'(gpio_input[15:8]), 32'hA5);

        // port 0 input 3C
        port_sel = 2'd0;
        ext_val[7:0] = 8'h3C;
        step();
        step();
        chk("p0_input_3C", 32'(gpio_input[7:0]), 32'h3C);
        chk("rd_3C", 32'(rd_data), 32'h3C);

        // out-of-range port
        port_sel = 2'd3; load_gpio = 1'b1; load_tris = 1'b1; alu_output = 8'hFF;
        step();
        load_gpio = 1'b0; load_tris = 1'b0;
        chk("sel3_rd", 32'(rd_data), 32'h0);
        chk("sel3_p1_kept", 32'(gpio_bus[15:8]), 32'hA5);
        chk("sel3_p2_tris", 32'(m_tris[23:16]), 32'hFF);
        step();

        // interrupt-on-change on port 2
        ioc_clear = 3'b111;
        step();
        ioc_clear = 3'b000;
        ext_val[16] = 1'b1;
        step(); step(); step();
`ifdef GPIO_IOC_EN
        exp_f = 3'b100;
`else
        exp_f = 3'b000;
`endif
        chk("ioc_set", 32'(ioc_flag), 32'(exp_f));
        chk("ioc_irq", 32'(irq), 32'(|exp_f));
        ext_val[16] = 1'b0;
        step(); step();
        ioc_clear = 3'b100;
        step();
        ioc_clear = 3'b000;
        chk("ioc_set_wins", 32'(ioc_flag), 32'(exp_f));
        ioc_clear = 3'b100;
        step();
        ioc_clear = 3'b000;
        chk("ioc_cleared", 32'(ioc_flag), 32'h0);
        chk("ioc_irq_low", 32'(irq), 32'h0);

        // randomized traffic
        for (int i = 0; i < 1500; i++) begin
            port_sel   = 2'($urandom_range(0, 3));
            load_tris  = ($urandom_range(0, 3) == 0);
            load_gpio  = ($urandom_range(0, 1) == 0);
            alu_output = 8'($urandom);
            if ($urandom_range(0, 3) == 0) ext_val = 24'($urandom);
            ioc_clear  = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b0;
            step();
        end

        // reset in the middle of a write while port 0 drives 55
        port_sel = 2'd0; load_tris = 1'b1; load_gpio = 1'b0; alu_output = 8'h00;
        ioc_clear = '0;
        step();
        load_tris = 1'b0; load_gpio = 1'b1; alu_output = 8'h55;
        step();
        chk("p0_drive_55", 32'(gpio_bus[7:0]), 32'h55);
        alu_output = 8'h12;
        #2 rst = 1'b0;
        #1;
        model_reset();
        ext_en = '1;
        ext_val[7:0] = 8'hAA;
        #1;
        chk("async_hiz", 32'(gpio_bus[7:0]), 32'hAA);
        chk("async_input0", 32'(gpio_input), 32'h0);
        chk("async_flag0", 32'(ioc_flag), 32'h0);
        chk("async_irq0", 32'(irq), 32'h0);
        load_gpio = 1'b0;
        step();
        ext_val = 24'hC3_5A_AA;
        step();
        #2 rst = 1'b1;
        step();
        step();
        chk("rel_no_flag", 32'(ioc_flag), 32'h0);

        for (int i = 0; i < 800; i++) begin
            port_sel   = 2'($urandom_range(0, 3));
            load_tris  = ($urandom_range(0, 3) == 0);
            load_gpio  = ($urandom_range(0, 1) == 0);
            alu_output = 8'($urandom);
            if ($urandom_range(0, 2) == 0) ext_val = 24'($urandom);
            ioc_clear  = ($urandom_range(0, 4) == 0) ? 3'($urandom) : 3'b0;
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
